// File: rtl/pwm_ctrl_scheduler.sv
// Multi-channel PWM controller: register writes over valid/ready, shared prescaled
// period counter, and a commit FSM that moves shadow duties to active only at a wrap.
module pwm_ctrl_scheduler #(
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [3:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_tick,
   output logic              addr_err
);

   localparam logic [3:0] CH_LIMIT   = 4'(NUM_CH);
   localparam logic [3:0] ADDR_CTRL  = 4'd8;
   localparam logic [3:0] ADDR_PRESC = 4'd9;
   localparam logic [3:0] ADDR_COMMIT = 4'd15;

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_APPLY} state_t;

   state_t     state, state_nxt;
   logic [7:0] shadow_duty [NUM_CH];
   logic [7:0] active_duty [NUM_CH];
   logic       enable;
   logic [7:0] prescale;
   logic [7:0] presc;
   logic [7:0] cnt;
   logic       wr_fire;
   logic       cnt_adv;
   logic       wrap;
   logic       commit_req;
   logic       apply;

   function automatic logic addr_mapped(input logic [3:0] a);
      return (a < CH_LIMIT) || (a == ADDR_CTRL) || (a == ADDR_PRESC) || (a == ADDR_COMMIT);
   endfunction

   assign wr_fire    = wr_valid && wr_ready;
   assign cnt_adv    = enable && (presc == prescale);
   assign wrap       = cnt_adv && (cnt == 8'hFF);
   assign commit_req = wr_fire && (wr_addr == ADDR_COMMIT);

   // Register file; active duties only change in the APPLY cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         enable   <= 1'b0;
         prescale <= 8'd0;
         addr_err <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_duty[i] <= 8'd0;
            active_duty[i] <= 8'd0;
         end
      end else begin
         if (wr_fire) begin
            case (wr_addr)
               ADDR_CTRL:  enable   <= wr_data[0];
               ADDR_PRESC: prescale <= wr_data;
               default: ;
            endcase
         end
         if (wr_fire && !addr_mapped(wr_addr))
            addr_err <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_fire && (wr_addr == 4'(i)))
               shadow_duty[i] <= wr_data;
            if (apply)
               active_duty[i] <= shadow_duty[i];
         end
      end
   end

   // presc wraps through 255 when PRESCALE shrinks below it, so no early advance
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         presc <= 8'd0;
         cnt   <= 8'd0;
      end else if (cnt_adv) begin
         presc <= 8'd0;
         cnt   <= cnt + 8'd1;
      end else begin
         presc <= presc + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out     <= '0;
         period_tick <= 1'b0;
      end else begin
         period_tick <= wrap;
         for (int i = 0; i < NUM_CH; i++)
            pwm_out[i] <= enable && (cnt < active_duty[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // With the counter stopped there is no wrap to wait for, so PENDING lasts one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (commit_req) state_nxt = S_PENDING;
         S_PENDING: if (!enable || wrap) state_nxt = S_APPLY;
         S_APPLY:   state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ready = (state == S_IDLE);
      apply    = (state == S_APPLY);
   end

endmodule

// File: tb/tb_pwm_ctrl_scheduler.sv
// Self-checking bench for pwm_ctrl_scheduler: register-map table, commit timing,
// prescaler corner cases and a per-cycle pwm/tick scoreboard derived from the edge count.
module tb_pwm_ctrl_scheduler;

   localparam int NUM_CH = 4;
   localparam int NEVER  = 32'h7fffffff;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_valid;
   logic              wr_ready;
   logic [3:0]        wr_addr;
   logic [7:0]        wr_data;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_tick;
   logic              addr_err;

   pwm_ctrl_scheduler #(.NUM_CH(NUM_CH)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .pwm_out(pwm_out),
      .period_tick(period_tick), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
      logic       exp_err;
   } vec_t;

   typedef struct {
      int         edge_n;
      logic [4:0] exp;   // {pwm_out, period_tick}
   } sb_t;

   sb_t        sb_q[$];
   vec_t       tbl[6];
   int         n_chk = 0;
   int         n_fail = 0;
   int         ecnt = 0;
   int         t_en = 0;
   int         sw_edge = NEVER;
   int         acc = 0;
   bit         chk_en = 1'b0;
   logic [7:0] shadow_m [NUM_CH];
   logic [7:0] d_cur [NUM_CH];
   logic [7:0] d_nxt [NUM_CH];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // With PRESCALE = 0, cnt after edge e is (e - t_en) mod 256; pwm_out lags it by one edge
   initial begin
      forever begin
         @(posedge clk);
         ecnt = ecnt + 1;
         if (chk_en) begin
            sb_t        s;
            logic [7:0] d;
            int         c;
            s.edge_n = ecnt;
            s.exp    = '0;
            if (ecnt > t_en) begin
               c = (ecnt - 1 - t_en) % 256;
               for (int i = 0; i < NUM_CH; i++) begin
                  d = (ecnt >= sw_edge) ? d_nxt[i] : d_cur[i];
                  s.exp[i+1] = (c < int'(d));
               end
               s.exp[0] = ((ecnt - t_en) % 256 == 0);
            end
            sb_q.push_back(s);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            check($sformatf("pwm_sb@%0d", s.edge_n), int'({pwm_out, period_tick}), int'(s.exp));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sw_edge = NEVER;
      for (int i = 0; i < NUM_CH; i++) begin
         shadow_m[i] = 8'd0;
         d_cur[i]    = 8'd0;
         d_nxt[i]    = 8'd0;
      end
   endtask

   task automatic wr_write(input logic [3:0] a, input logic [7:0] d);
      int n;
      n = 0;
      while (!wr_ready && n < 2000) begin
         step(1);
         n++;
      end
      if (!wr_ready) check("wr_ready_wait_timeout", 0, 1);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      acc      = ecnt + 1;
      step(1);
      wr_valid = 1'b0;
      if (int'(a) < NUM_CH) shadow_m[a[1:0]] = d;
   endtask

   task automatic do_commit(input bit en_now, input bit poke);
      int c, r, w, exp_rdy, got;
      wr_write(4'd15, 8'h00);
      c = acc;
      check("commit_ready_low", int'(wr_ready), 0);
      if (en_now) begin
         r = (c - t_en) % 256;
         w = c + 256 - r;
         exp_rdy = w + 1;
         for (int i = 0; i < NUM_CH; i++) begin
            d_cur[i] = d_nxt[i];
            d_nxt[i] = shadow_m[i];
         end
         sw_edge = w + 2;
      end else begin
         exp_rdy = c + 2;
         for (int i = 0; i < NUM_CH; i++) begin
            d_cur[i] = shadow_m[i];
            d_nxt[i] = shadow_m[i];
         end
         sw_edge = NEVER;
      end
      if (poke) begin
         wr_valid = 1'b1;
         wr_addr  = 4'd1;
         wr_data  = 8'd77;
         step(20);
         check("poke_ready_low", int'(wr_ready), 0);
         wr_valid = 1'b0;
      end
      got = -1;
      for (int k = 0; k < 700; k++) begin
         step(1);
         if (wr_ready) begin
            got = ecnt;
            break;
         end
      end
      check("commit_ready_edge", got, exp_rdy);
   endtask

   task automatic measure(input int bound, output int len, output int highs, output int tick_w);
      len = -1;
      highs = 0;
      for (int k = 0; k < bound; k++) begin
         if (period_tick) break;
         step(1);
      end
      step(1);
      tick_w = int'(period_tick);
      for (int j = 1; j <= bound; j++) begin
         if (pwm_out != '0) highs++;
         if (period_tick) begin
            len = j;
            break;
         end
         step(1);
      end
   endtask

   initial begin
      int len, highs, tick_w, t0, got;
      rst = 1'b1;
      wr_valid = 1'b0;
      wr_addr = 4'd0;
      wr_data = 8'd0;
      tbl[0] = '{4'd0,  8'd5,  1'b0};
      tbl[1] = '{4'd9,  8'd0,  1'b0};
      tbl[2] = '{4'd12, 8'd99, 1'b1};
      tbl[3] = '{4'd2,  8'd44, 1'b1};
      tbl[4] = '{4'd5,  8'd1,  1'b1};
      tbl[5] = '{4'd8,  8'd0,  1'b1};

      do_reset();
      check("rst_wr_ready", int'(wr_ready), 1);
      check("rst_pwm_out", int'(pwm_out), 0);
      check("rst_period_tick", int'(period_tick), 0);
      check("rst_addr_err", int'(addr_err), 0);

      // Enabled with zero duties: tick period at PRESCALE 0 and 1
      wr_write(4'd8, 8'd1);
      measure(600, len, highs, tick_w);
      check("tick_period_presc0", len, 256);
      check("zero_duty_highs", highs, 0);
      check("tick_width", tick_w, 0);
      wr_write(4'd9, 8'd1);
      measure(1200, len, highs, tick_w);
      check("tick_period_presc1", len, 512);

      // PRESCALE shrinks below a running presc: presc runs to 255 before normal advance
      wr_write(4'd8, 8'd0);
      wr_write(4'd9, 8'd5);
      wr_write(4'd8, 8'd1);
      t0 = acc;
      step(3);
      wr_write(4'd9, 8'd2);
      got = -1;
      for (int k = 0; k < 1200; k++) begin
         if (period_tick) begin
            got = ecnt;
            break;
         end
         step(1);
      end
      check("presc_shrink_wrap_edge", got, t0 + 1024);

      // Two channels committed while running
      wr_write(4'd9, 8'd0);
      wr_write(4'd8, 8'd0);
      wr_write(4'd8, 8'd1);
      t_en = acc;
      chk_en = 1'b1;
      wr_write(4'd0, 8'd64);
      wr_write(4'd1, 8'd128);
      do_commit(1'b1, 1'b0);
      step(300);

      // Shadow write without commit, then commit mid-period with a refused write held
      wr_write(4'd0, 8'd200);
      step(768);
      while (((ecnt + 1 - t_en) % 256) != 100) step(1);
      do_commit(1'b1, 1'b1);
      step(520);
      chk_en = 1'b0;
      step(2);

      // Commit while disabled completes without a wrap
      wr_write(4'd8, 8'd0);
      wr_write(4'd0, 8'd10);
      wr_write(4'd2, 8'd30);
      wr_write(4'd3, 8'd255);
      do_commit(1'b0, 1'b0);
      check("disabled_pwm_out", int'(pwm_out), 0);
      check("disabled_tick", int'(period_tick), 0);
      wr_write(4'd8, 8'd1);
      t_en = acc;
      chk_en = 1'b1;
      step(300);
      chk_en = 1'b0;
      step(2);

      // Register map and sticky addr_err
      wr_write(4'd8, 8'd0);
      for (int i = 0; i < 6; i++) begin
         wr_write(tbl[i].addr, tbl[i].data);
         check($sformatf("tbl%0d_addr_err", i), int'(addr_err), int'(tbl[i].exp_err));
         check($sformatf("tbl%0d_wr_ready", i), int'(wr_ready), 1);
      end
      do_commit(1'b0, 1'b0);
      wr_write(4'd8, 8'd1);
      t_en = acc;
      chk_en = 1'b1;
      step(300);
      chk_en = 1'b0;
      step(2);
      check("err_sticky_before_rst", int'(addr_err), 1);
      do_reset();
      check("err_cleared_by_rst", int'(addr_err), 0);

      // Reset while PENDING discards the commit and the duties
      wr_write(4'd8, 8'd1);
      t_en = acc;
      wr_write(4'd0, 8'd50);
      wr_write(4'd15, 8'd0);
      check("pending_ready_low", int'(wr_ready), 0);
      step(5);
      do_reset();
      check("midrst_wr_ready", int'(wr_ready), 1);
      check("midrst_pwm_out", int'(pwm_out), 0);
      check("midrst_tick", int'(period_tick), 0);
      wr_write(4'd8, 8'd1);
      t_en = acc;
      chk_en = 1'b1;
      do_commit(1'b1, 1'b0);
      step(300);
      chk_en = 1'b0;
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
